// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
// Holds the loader state encoding and the last-word bit-count helper.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } ld_state_t;

    // Number of bits taken from the final word of a load (a full word when CHAIN_LEN divides evenly).
    function automatic int last_word_bits(input int chain_len, input int word_w);
        int rem;
        rem = chain_len % word_w;
        return (rem == 0) ? word_w : rem;
    endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Serial-to-word packer for chain readback; built only when CCFF_READBACK_EN is defined.
// Collects ccff_tail bits LSB-first and emits a word when full or on the last bit of a load.
`ifdef CCFF_READBACK_EN
module ccff_rb_packer #(
    parameter int WORD_W = 32
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              sample,
    input  logic              bit_in,
    input  logic              last,
    input  logic              clear,
    output logic [WORD_W-1:0] rb_word,
    output logic              rb_valid
);
    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic [WORD_W-1:0] acc_reg;
    logic [WORD_W-1:0] filled;
    logic [IW-1:0]     cnt_reg;

    always_comb begin
        filled          = acc_reg;
        filled[cnt_reg] = bit_in;
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            acc_reg  <= '0;
            cnt_reg  <= '0;
            rb_word  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (clear) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end else if (sample) begin
                if (cnt_reg == IW'(WORD_W - 1) || last) begin
                    rb_word  <= filled;
                    rb_valid <= 1'b1;
                    acc_reg  <= '0;
                    cnt_reg  <= '0;
                end else begin
                    acc_reg <= filled;
                    cnt_reg <= cnt_reg + IW'(1);
                end
            end
        end
    end

endmodule
`endif

// File: rtl/ccff_chain_loader.sv
// Loads one ccff_head->ccff_tail configuration chain from a word stream, LSB-first, CHAIN_LEN bits.
// Optional chain readback packer is enabled with the CCFF_READBACK_EN macro.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 56,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_word,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
`ifdef CCFF_READBACK_EN
    output logic [WORD_W-1:0] rb_word,
    output logic              rb_valid,
`endif
    output logic              busy,
    output logic              done,
    output logic              aborted
);
    localparam int WL_W      = $clog2(WORD_W + 1);
    localparam int LAST_BITS = last_word_bits(CHAIN_LEN, WORD_W);

    ld_state_t         state_reg, state_next;
    logic [WORD_W-1:0] sreg_reg, sreg_next;
    logic [CNT_W-1:0]  bits_left_reg, bits_left_next;
    logic [WL_W-1:0]   word_left_reg, word_left_next;
    logic              aborted_reg, aborted_next;

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_reg     <= IDLE;
            sreg_reg      <= '0;
            bits_left_reg <= '0;
            word_left_reg <= '0;
            aborted_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            sreg_reg      <= sreg_next;
            bits_left_reg <= bits_left_next;
            word_left_reg <= word_left_next;
            aborted_reg   <= aborted_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        sreg_next      = sreg_reg;
        bits_left_next = bits_left_reg;
        word_left_next = word_left_reg;
        aborted_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                bits_left_next = CNT_W'(CHAIN_LEN);
                if (start) state_next = FETCH;
            end
            FETCH: begin
                if (abort) begin
                    state_next   = IDLE;
                    aborted_next = 1'b1;
                end else if (cfg_valid) begin
                    sreg_next = cfg_word;
                    // Only the final fetch sees a remainder this small, so it selects the short word.
                    word_left_next = (bits_left_reg == CNT_W'(LAST_BITS)) ? WL_W'(LAST_BITS)
                                                                          : WL_W'(WORD_W);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_next   = IDLE;
                    aborted_next = 1'b1;
                end else begin
                    sreg_next      = sreg_reg >> 1;
                    bits_left_next = bits_left_reg - CNT_W'(1);
                    word_left_next = word_left_reg - WL_W'(1);
                    if (word_left_reg == WL_W'(1))
                        state_next = (bits_left_reg == CNT_W'(1)) ? DONE : FETCH;
                end
            end
            DONE: begin
                state_next   = IDLE;
                aborted_next = abort;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode registered state only, so reset drops them without waiting for a clock.
    assign cfg_ready     = (state_reg == FETCH);
    assign ccff_shift_en = (state_reg == SHIFT);
    assign ccff_head     = ccff_shift_en & sreg_reg[0];
    assign busy          = (state_reg != IDLE);
    assign done          = (state_reg == DONE);
    assign aborted       = aborted_reg;

`ifdef CCFF_READBACK_EN
    ccff_rb_packer #(
        .WORD_W(WORD_W)
    ) u_rb_packer (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .sample   (ccff_shift_en & ~abort),
        .bit_in   (ccff_tail),
        .last     (bits_left_reg == CNT_W'(1)),
        .clear    (abort),
        .rb_word  (rb_word),
        .rb_valid (rb_valid)
    );
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: zero-stall, stalled, abort, async reset and optional readback.
// A 56-bit chain model sits on ccff_head/ccff_tail and shifts on ccff_shift_en.
module tb_ccff_chain_loader;
    localparam int WORD_W    = 32;
    localparam int CHAIN_LEN = 56;

    logic              prog_clk = 1'b0;
    logic              pReset   = 1'b0;
    logic              start    = 1'b0;
    logic              abort    = 1'b0;
    logic [WORD_W-1:0] cfg_word = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready, ccff_head, ccff_shift_en, ccff_tail;
    logic              busy, done, aborted;
`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_word;
    logic              rb_valid;
`endif

    ccff_chain_loader #(.WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN)) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start),
        .abort         (abort),
        .cfg_word      (cfg_word),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
`ifdef CCFF_READBACK_EN
        .rb_word       (rb_word),
        .rb_valid      (rb_valid),
`endif
        .busy          (busy),
        .done          (done),
        .aborted       (aborted)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: the first bit shifted in ends up at chain[0], next to ccff_tail.
    logic [CHAIN_LEN-1:0] chain = '0;
    logic                 preload_req = 1'b0;
    logic [CHAIN_LEN-1:0] preload_val = '0;
    always @(posedge prog_clk) begin
        if (preload_req)        chain <= preload_val;
        else if (ccff_shift_en) chain <= {ccff_head, chain[CHAIN_LEN-1:1]};
    end
    assign ccff_tail = chain[0];

    logic [WORD_W-1:0]    w0 = 32'hA5A5_0F0F;
    logic [WORD_W-1:0]    w1 = 32'h00C3_3CFF;
    logic [CHAIN_LEN-1:0] exp_bits;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    logic en_log    [0:99];
    logic ready_log [0:99];
    logic busy_log  [0:99];
    int   rb_n;
    int   rb_cyc [0:1];
    logic [WORD_W-1:0] rb_dat [0:1];

    // One load; cycle 0 is the cycle start is driven. Each loop pass samples at the falling edge.
    task automatic run_load(input int stall_cyc, input int stall_len, input int abort_cyc,
                            output int done_cyc, output int ab_cyc, output int shifts,
                            output logic [CHAIN_LEN-1:0] serial);
        int widx;
        widx = 0; done_cyc = -1; ab_cyc = -1; shifts = 0; serial = '0; rb_n = 0;
        for (int i = 0; i < 100; i++) begin
            en_log[i] = 1'b0; ready_log[i] = 1'b0; busy_log[i] = 1'b0;
        end
        @(negedge prog_clk);
        for (int n = 0; n < 100; n++) begin
            start     = (n == 0);
            abort     = (n == abort_cyc);
            cfg_word  = (widx == 0) ? w0 : w1;
            cfg_valid = !(n >= stall_cyc && n < stall_cyc + stall_len);
            en_log[n] = ccff_shift_en; ready_log[n] = cfg_ready; busy_log[n] = busy;
            if (ccff_shift_en && shifts < CHAIN_LEN) begin
                serial[shifts] = ccff_head;
                shifts++;
            end
            if (done)    done_cyc = n;
            if (aborted) ab_cyc = n;
`ifdef CCFF_READBACK_EN
            if (rb_valid && rb_n < 2) begin
                rb_cyc[rb_n] = n; rb_dat[rb_n] = rb_word; rb_n++;
            end
`endif
            if (cfg_ready && cfg_valid && !abort) widx++;
            if ((done_cyc >= 0 && n > done_cyc) || (ab_cyc >= 0 && n > ab_cyc)) break;
            @(negedge prog_clk);
        end
        start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
    endtask

    int dc, ac, sh;
    logic [CHAIN_LEN-1:0] ser, snap;

    initial begin
        exp_bits = {w1[23:0], w0};
        repeat (3) @(negedge prog_clk);
        check("reset_outs_in_reset", {busy, cfg_ready, ccff_shift_en, ccff_head, done, aborted}, 6'b0);
        pReset = 1'b1;
        @(negedge prog_clk);
        check("reset_outs_after_release", {busy, cfg_ready, ccff_shift_en, ccff_head, done, aborted}, 6'b0);
`ifdef CCFF_READBACK_EN
        check("reset_rb", {rb_valid, rb_word}, '0);
`endif

        // Zero-stall load
        run_load(-1, 0, -1, dc, ac, sh, ser);
        check("t1_ready_c0", ready_log[0], 1'b0);
        check("t1_ready_c1", ready_log[1], 1'b1);
        check("t1_en_c1", en_log[1], 1'b0);
        check("t1_en_c2", en_log[2], 1'b1);
        check("t1_en_c34", en_log[34], 1'b0);
        check("t1_en_c35", en_log[35], 1'b1);
        check("t1_done_cycle", dc, 59);
        check("t1_shift_count", sh, 56);
        check("t1_serial", ser, exp_bits);
        check("t1_chain", chain, exp_bits);
        check("t1_busy_after", busy_log[60], 1'b0);

        // Stalled second fetch
        run_load(34, 5, -1, dc, ac, sh, ser);
        check("t2_en_c36", en_log[36], 1'b0);
        check("t2_ready_c38", ready_log[38], 1'b1);
        check("t2_done_cycle", dc, 64);
        check("t2_shift_count", sh, 56);
        check("t2_serial", ser, exp_bits);

        // Abort mid-shift, then a full reload
        run_load(-1, 0, 20, dc, ac, sh, ser);
        check("t3_aborted_cycle", ac, 21);
        check("t3_no_done", dc, -1);
        check("t3_busy_c21", busy_log[21], 1'b0);
        run_load(-1, 0, -1, dc, ac, sh, ser);
        check("t3_reload_done", dc, 59);
        check("t3_reload_chain", chain, exp_bits);

        // Asynchronous reset at cycle 10
        @(negedge prog_clk);
        start = 1'b1; cfg_valid = 1'b1; cfg_word = w0;
        @(negedge prog_clk);
        start = 1'b0;
        repeat (9) @(negedge prog_clk);
        check("t4_shifting_before_reset", ccff_shift_en, 1'b1);
        snap = chain;
        pReset = 1'b0;
        #1;
        check("t4_outs_in_reset", {busy, cfg_ready, ccff_shift_en, ccff_head, done, aborted}, 6'b0);
        repeat (3) @(negedge prog_clk);
        check("t4_chain_held", chain, snap);
        pReset = 1'b1; cfg_valid = 1'b0;
        run_load(-1, 0, -1, dc, ac, sh, ser);
        check("t4_after_done", dc, 59);
        check("t4_after_serial", ser, exp_bits);

`ifdef CCFF_READBACK_EN
        // Readback of a known prior chain pattern
        @(negedge prog_clk);
        preload_val = 56'h9E_3712_C4D5_6A0B;
        preload_req = 1'b1;
        @(negedge prog_clk);
        preload_req = 1'b0;
        snap = preload_val;
        run_load(-1, 0, -1, dc, ac, sh, ser);
        check("t5_rb_count", rb_n, 2);
        check("t5_rb0_cycle", rb_cyc[0], 34);
        check("t5_rb0_word", rb_dat[0], snap[31:0]);
        check("t5_rb1_cycle", rb_cyc[1], 59);
        check("t5_rb1_word", rb_dat[1], {8'h00, snap[55:32]});
        check("t5_chain", chain, exp_bits);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
